ws2812_strip_ctrl: RTL and testbench

WS2812_STRIP_CTRL -- requirements
Module: ws2812_strip_ctrl

---
 rtl/ws2812_strip_ctrl.sv | 137 +++++++++++++
 tb/tb_ws2812_strip_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_strip_ctrl.sv
// WS2812 strip frame controller: buffers N_LED RGB pixels and streams them as GRB words to a serializer.
// Build option: define WS2812_AUTO_REFRESH_EN to repeat frames continuously after the first refresh.
module ws2812_strip_ctrl #(
  parameter real         F_CLK   = 48e6,
  parameter int unsigned N_LED   = 8,
  parameter real         T_RESET = 60e-6,
  localparam int unsigned AW     = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_rgb,
  input  logic          refresh,
  output logic [23:0]   tx_data,
  output logic          tx_start,
  input  logic          tx_bsy,
  output logic          busy,
  output logic          done
);

  // Small guard keeps products such as 1e-6 * 48e6 from rounding up a whole cycle.
  localparam real         RstExact = T_RESET * F_CLK - 1e-6;
  localparam int unsigned RstTrunc = $rtoi(RstExact);
  localparam int unsigned N_RST    = ($itor(RstTrunc) < RstExact) ? RstTrunc + 1 : RstTrunc;
  localparam int unsigned CW       = $clog2(N_RST + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitHi, StWaitLo, StLatch} state_e;

  function automatic logic [23:0] grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  logic [23:0]   pix_q [N_LED];
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [23:0]   tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Pixel buffer is deliberately outside reset so contents survive an aborted frame.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < N_LED)) begin
      pix_q[wr_addr] <= wr_rgb;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    if (refresh && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (refresh || pend_q) begin
          state_d = StLoad;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      StLoad: begin
        tx_data_d  = grb(pix_q[idx_q]);
        tx_start_d = 1'b1;
        state_d    = StSend;
      end
      StSend: state_d = StWaitHi;
      StWaitHi: begin
        if (tx_bsy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!tx_bsy) begin
          if (idx_q == AW'(N_LED - 1)) begin
            state_d = StLatch;
            cnt_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StLatch: begin
        if (cnt_q == CW'(N_RST - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
          pend_d  = 1'b1;
`else
          pend_d  = pend_d;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ws2812_strip_ctrl.sv
// Self-checking bench for ws2812_strip_ctrl: 3-pixel strip, 48-cycle latch, stub serializer
// that holds tx_bsy high for 10 cycles starting the cycle after each tx_start.
module tb_ws2812_strip_ctrl;

  localparam int NLed = 3;
  // Cycles from the first tx_bsy-low cycle to the done cycle: 48 latch cycles in between.
  localparam int GapExp = 49;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_rgb = '0;
  logic        refresh = 1'b0;
  logic        tx_bsy = 1'b0;
  logic [23:0] tx_data;
  logic        tx_start;
  logic        busy;
  logic        done;

  ws2812_strip_ctrl #(
    .F_CLK  (48e6),
    .N_LED  (NLed),
    .T_RESET(1e-6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_rgb  (wr_rgb),
    .refresh (refresh),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_bsy  (tx_bsy),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_fall = 0;
  int          hold_err = 0;
  int          bsy_left = 0;
  bit          prev_bsy = 1'b0;
  bit          in_flight = 1'b0;
  bit          seen_bsy = 1'b0;
  bit          arm = 1'b0;
  logic [23:0] hold_w = '0;
  logic [23:0] got_q[$];
  int          start_q[$];
  int          done_q[$];
  int          gap_q[$];
  logic [23:0] model[NLed];
  logic [23:0] snap[NLed];

  function automatic logic [23:0] grb(input logic [23:0] rgb);
    logic [7:0] r, g, b;
    {r, g, b} = rgb;
    return {g, r, b};
  endfunction

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_start === 1'b1) begin
      got_q.push_back(tx_data);
      start_q.push_back(cyc);
      arm = 1'b1;
      hold_w = tx_data;
      in_flight = 1'b1;
      seen_bsy = 1'b0;
    end else if (in_flight) begin
      if (tx_data !== hold_w) hold_err++;
      if (tx_bsy) seen_bsy = 1'b1;
      else if (seen_bsy) in_flight = 1'b0;
    end
    if (!rst) in_flight = 1'b0;
    if (prev_bsy && !tx_bsy) last_fall = cyc;
    prev_bsy = tx_bsy;
    if (done === 1'b1) begin
      done_q.push_back(cyc);
      gap_q.push_back(cyc - last_fall);
    end
  end

  // Serializer stub.
  always @(posedge clk) begin
    #1;
    if (arm) begin
      arm = 1'b0;
      tx_bsy = 1'b1;
      bsy_left = 9;
    end else if (bsy_left > 0) begin
      bsy_left--;
    end else begin
      tx_bsy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_rgb = d;
    tick(1);
    wr_en = 1'b0;
    if (int'(a) < NLed) model[a] = d;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick(1);
    refresh = 1'b0;
  endtask

  task automatic take_snap();
    for (int i = 0; i < NLed; i++) snap[i] = grb(model[i]);
  endtask

  task automatic clear_logs();
    got_q.delete();
    start_q.delete();
    done_q.delete();
    gap_q.delete();
    hold_err = 0;
  endtask

  task automatic wait_dones(input int n, input string tag);
    int b = 0;
    while (done_q.size() < n && b < 2000) begin
      tick(1);
      b++;
    end
    chk({tag, "_done_timeout"}, 32'(done_q.size() >= n), 32'd1);
  endtask

  task automatic wait_starts(input int n, input string tag);
    int b = 0;
    while (start_q.size() < n && b < 2000) begin
      tick(1);
      b++;
    end
    chk({tag, "_start_timeout"}, 32'(start_q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base);
    for (int i = 0; i < NLed; i++) begin
      chk($sformatf("%s_w%0d", tag, i),
          (got_q.size() > base + i) ? 32'(got_q[base + i]) : 32'hFFFF_FFFF, 32'(snap[i]));
    end
  endtask

  initial begin
    logic [23:0] spec_px[NLed];
    logic [23:0] spec_tx[NLed];
    int lf0;
    int b;
    spec_px[0] = 24'h112233; spec_px[1] = 24'h445566; spec_px[2] = 24'h778899;
    spec_tx[0] = 24'h221133; spec_tx[1] = 24'h554466; spec_tx[2] = 24'h887799;

    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick(1);

`ifdef WS2812_AUTO_REFRESH_EN
    for (int i = 0; i < NLed; i++) write_px(2'(i), spec_px[i]);
    take_snap();
    clear_logs();
    pulse_refresh();
    wait_dones(3, "auto");
    for (int f = 0; f < 3; f++) begin
      check_frame($sformatf("auto_f%0d", f), f * NLed);
      chk($sformatf("auto_gap%0d", f), (gap_q.size() > f) ? 32'(gap_q[f]) : 32'hFFFF_FFFF,
          32'(GapExp));
    end
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("auto_restart%0d", f), 32'(start_q[(f + 1) * NLed]), 32'(done_q[f] + 2));
    end
    chk("auto_hold", 32'(hold_err), 32'd0);
`else
    // Reference vector frame plus start latency.
    for (int i = 0; i < NLed; i++) write_px(2'(i), spec_px[i]);
    clear_logs();
    pulse_refresh();
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_no_start_yet", 32'(tx_start), 32'd0);
    tick(1);
    chk("lat_start", 32'(tx_start), 32'd1);
    chk("lat_word0", 32'(tx_data), 32'h221133);
    wait_dones(1, "vec");
    for (int i = 0; i < NLed; i++) begin
      chk($sformatf("vec_w%0d", i), (got_q.size() > i) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
          32'(spec_tx[i]));
    end
    chk("vec_starts", 32'(start_q.size()), 32'd3);
    chk("vec_gap", 32'(gap_q[0]), 32'(GapExp));
    chk("vec_hold", 32'(hold_err), 32'd0);
    tick(2);
    chk("vec_idle_busy", 32'(busy), 32'd0);

    // Random buffer contents, including ignored writes to address 3.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 5; w++) write_px(2'($urandom_range(0, 3)), 24'($urandom));
      take_snap();
      clear_logs();
      pulse_refresh();
      wait_dones(1, $sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r), 0);
      chk($sformatf("rnd%0d_gap", r), 32'(gap_q[0]), 32'(GapExp));
      chk($sformatf("rnd%0d_hold", r), 32'(hold_err), 32'd0);
      tick(2);
    end

    // Out-of-range write leaves the reference frame unchanged.
    for (int i = 0; i < NLed; i++) write_px(2'(i), spec_px[i]);
    write_px(2'd3, 24'hABCDEF);
    clear_logs();
    pulse_refresh();
    wait_dones(1, "oor");
    for (int i = 0; i < NLed; i++) begin
      chk($sformatf("oor_w%0d", i), (got_q.size() > i) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
          32'(spec_tx[i]));
    end
    tick(2);

    // Refreshes during a frame merge into exactly one extra frame.
    take_snap();
    clear_logs();
    pulse_refresh();
    wait_starts(2, "pend");
    pulse_refresh();
    wait_starts(3, "pend");
    pulse_refresh();
    wait_dones(2, "pend");
    tick(300);
    chk("pend_dones", 32'(done_q.size()), 32'd2);
    chk("pend_words", 32'(got_q.size()), 32'd6);
    chk("pend_restart", 32'(start_q[3]), 32'(done_q[0] + 2));
    check_frame("pend_f0", 0);
    check_frame("pend_f1", NLed);

    // Write to the pixel being loaded: old value goes out, new value next frame.
    take_snap();
    clear_logs();
    lf0 = last_fall;
    pulse_refresh();
    b = 0;
    while (last_fall == lf0 && b < 500) begin
      tick(1);
      b++;
    end
    chk("race_fall_timeout", 32'(last_fall != lf0), 32'd1);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_rgb = 24'hFFFFFF;
    tick(1);
    wr_en = 1'b0;
    wait_dones(1, "race");
    check_frame("race_old", 0);
    model[1] = 24'hFFFFFF;
    take_snap();
    tick(2);
    clear_logs();
    pulse_refresh();
    wait_dones(1, "race_new");
    check_frame("race_new", 0);
    tick(2);

    // Asynchronous reset mid-word aborts the frame; buffer survives.
    take_snap();
    clear_logs();
    pulse_refresh();
    wait_starts(2, "arst");
    tick(4);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(100);
    chk("arst_no_done", 32'(done_q.size()), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);
    clear_logs();
    pulse_refresh();
    wait_dones(1, "arst_re");
    chk("arst_re_words", 32'(got_q.size()), 32'd3);
    check_frame("arst_re", 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
